reg_writeback_unit: RTL

//  Producer side of the register-file write port: collects results from ALU and load paths,

---
 rtl/reg_writeback_unit_pkg.sv | 14 +
 rtl/reg_writeback_unit_if.sv | 29 ++
 rtl/reg_writeback_unit_wb_fifo.sv | 55 +++++
 rtl/reg_writeback_unit.sv | 67 ++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// reg_writeback_unit_pkg: shared widths, FIFO sizing and the buffered write-back entry type.
package reg_writeback_unit_pkg;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int NREG       = 2 ** ADDR_W;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: issue, ALU/load result, decode query and register-file write port signals.
interface reg_writeback_unit_if;
    import reg_writeback_unit_pkg::*;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic              rs1_pending;
    logic              reg_write_en;
    logic [ADDR_W-1:0] RegWriteAddr;
    logic [DATA_W-1:0] RegWriteData;
    logic              fifo_full;
    logic              fifo_empty;
    modport master (
        output issue_valid, issue_rd, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1_addr,
        input  alu_ready, ld_ready, rs1_pending, reg_write_en, RegWriteAddr, RegWriteData, fifo_full, fifo_empty
    );
    modport slave (
        input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1_addr,
        output alu_ready, ld_ready, rs1_pending, reg_write_en, RegWriteAddr, RegWriteData, fifo_full, fifo_empty
    );
endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// wb_fifo: 2-push/1-pop circular result buffer; entry A is stored ahead of entry B.
// Also reports whether any live entry targets the queried register.
module wb_fifo
    import reg_writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_a_i,
    input  wb_entry_t         entry_a_i,
    input  logic              push_b_i,
    input  wb_entry_t         entry_b_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] query_i,
    output wb_entry_t         head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              hit_o
);
    wb_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q, wr_b;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    assign wr_b    = wr_q + PTR_W'(push_a_i);
    assign count_d = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
    always_ff @(posedge clk) begin
        if (push_a_i) mem_q[wr_q] <= entry_a_i;
        if (push_b_i) mem_q[wr_b] <= entry_b_i;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
            rd_q    <= rd_q + PTR_W'(pop_i);
            count_q <= count_d;
            full_q  <= count_d == DEPTH_C;
            empty_q <= count_d == '0;
        end
    end
    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (CNT_W'(PTR_W'(PTR_W'(i) - rd_q)) < count_q && mem_q[i].addr == query_i) hit_o = 1'b1;
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: accepts ALU/load results into a buffer, drains one register-file write per
// cycle and tracks per-register pending writes for decode stalls.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
(
    input logic                 clk,
    input logic                 reset_n,
    reg_writeback_unit_if.slave bus
);
    logic              pop, push_ld, push_alu, hit, full, empty;
    logic [CNT_W-1:0]  count, free;
    wb_entry_t         head, ld_e, alu_e;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    assign pop           = !empty;
    assign free          = DEPTH_C - count + CNT_W'(pop);
    assign bus.ld_ready  = free != '0;
    assign bus.alu_ready = free > CNT_W'(1);
    assign push_ld       = bus.ld_valid & bus.ld_ready;
    assign push_alu      = bus.alu_valid & bus.alu_ready;
    assign ld_e          = '{addr: bus.ld_rd, data: bus.ld_data};
    assign alu_e         = '{addr: bus.alu_rd, data: bus.alu_data};
    wb_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_a_i  (push_ld),
        .entry_a_i (ld_e),
        .push_b_i  (push_alu),
        .entry_b_i (alu_e),
        .pop_i     (pop),
        .query_i   (bus.rs1_addr),
        .head_o    (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty),
        .hit_o     (hit)
    );
    // Issue is applied after the clear so a same-cycle re-issue keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (pop) pend_d[head.addr] = 1'b0;
        if (bus.issue_valid) pend_d[bus.issue_rd] = 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            we_q   <= pop;
            if (pop) begin
                waddr_q <= head.addr;
                wdata_q <= head.data;
            end
        end
    end
    assign bus.rs1_pending  = pend_q[bus.rs1_addr] | hit | (we_q & (waddr_q == bus.rs1_addr));
    assign bus.reg_write_en = we_q;
    assign bus.RegWriteAddr = waddr_q;
    assign bus.RegWriteData = wdata_q;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
endmodule
